prox_indicator: RTL and testbench
=================================

# prox_indicator

Multi-channel proximity indicator driven by ultrasonic echo-duration measurements. Each channel classifies its latest echo duration as NEAR or FAR, using hysteresis to avoid flicker. In NEAR the channel blinks its LED at a rate proportional to distance, so closer objects blink faster. The block sits between the per-sensor echo-timing front ends and the board LEDs, and flags channels whose sensor has stopped reporting.

## Interface
Parameters:
- N_CH, 2: number of independent sensor/LED channels.
- DUR_W, 32: width of one duration word, in clk cycles.
- NEAR_THRESH, 3500: a duration below this value enters NEAR (about 5 cm).
- FAR_THRESH, 4200: a duration at or above this value enters FAR. Must satisfy FAR_THRESH ≥ NEAR_THRESH.
- BLINK_SHIFT, 4: blink half-period = duration >> BLINK_SHIFT.
- STALE_CYCLES, 1_000_000: number of cycles without a measurement before a channel goes STALE. Must be ≥ 2.
- ACTIVE_LOW, 1: when 1, a lit LED drives led_out low.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- meas_valid  in  N_CH  one-cycle strobe per channel; the duration for that channel is valid in this cycle.
- meas_dur  in  N_CH*DUR_W  packed durations; channel i occupies [i*DUR_W +: DUR_W].
- led_out  out  N_CH  registered LED drive, polarity set by ACTIVE_LOW.
- near  out  N_CH  registered; high while the channel is in NEAR.
- stale  out  N_CH  registered; high while the channel is in STALE.

## Operation
- Each channel runs its own FSM with states STALE, FAR and NEAR. Reset state is STALE.
- On meas_valid[i], the duration d is latched into dur_q, and the FSM then moves as follows:
  - d < NEAR_THRESH → NEAR.
  - d ≥ FAR_THRESH → FAR.
  - Otherwise, in the hysteresis band: the state is held. If the current state is STALE, the channel goes to FAR.
- Stale timer, sized at clog2(STALE_CYCLES+1) bits:
  - Cleared on meas_valid.
  - Otherwise increments and saturates at STALE_CYCLES.
  - When it reaches STALE_CYCLES, the FSM goes to STALE.
  - If meas_valid arrives in the same cycle the timer would expire, meas_valid wins: the timer clears and the FSM is classified normally.
- Half-period H = max(1, dur_q >> BLINK_SHIFT), truncated to DUR_W bits.
- Blink counter bc and lit bit:
  - On entry to NEAR from FAR or STALE: lit=1, bc=0.
  - While in NEAR: when bc ≥ H−1, lit toggles and bc clears to 0; otherwise bc increments.
  - A new NEAR measurement updates H immediately without resetting bc. If bc already exceeds the new H−1, the toggle happens on the next cycle.
  - In FAR or STALE: lit=0, bc=0.
- Outputs:
  - led_out[i] = lit XOR ACTIVE_LOW.
  - near[i] = (state == NEAR).
  - stale[i] = (state == STALE).
- Channels share nothing except clk and rst. Simultaneous strobes on different channels are fully independent.

## Timing
- Reset values:
  - state = STALE, lit = 0, bc = 0, stale timer = 0, dur_q = 0.
  - led_out = {N_CH{ACTIVE_LOW}}, near = 0, stale = all ones.
- Latency: meas_valid sampled at edge t. near, stale and the first led_out change are visible after edge t; there are no combinational input-to-output paths.
- In steady NEAR, led_out toggles every H cycles, giving a full period of 2H.
- STALE timing: with no strobe after the one at edge t, stale rises after edge t+STALE_CYCLES.
- Reset asserted mid-blink or mid-timeout: all channels return to their reset values immediately (asynchronously). Operation resumes on the first meas_valid after reset deasserts.
- d = 0 gives H = 1, so the LED toggles every cycle. The maximum d is accepted without overflow.

## Structure
- Package prox_pkg holds:
  - the prox_state_t enum (STALE, FAR, NEAR);
  - the function half_period(dur, shift) that applies the max(1,·) clamp.
- Sub-module prox_channel holds one FSM, the stale timer and the blink logic, with scalar ports.
- The top level instantiates N_CH copies of prox_channel in a generate loop and slices meas_dur per channel.
- The parameter assertions (FAR_THRESH ≥ NEAR_THRESH, STALE_CYCLES ≥ 2) live in the top level.

## Test plan
- Reset release with no strobes:
  - led_out = 2'b11, near = 0, stale = 2'b11.
  - With STALE_CYCLES = 16, values stay unchanged.
- Ch0 strobe d = 1600 (H = 100):
  - Next cycle: near[0] = 1, stale[0] = 0, led_out[0] = 0 (lit).
  - led_out[0] then toggles every 100 cycles.
  - Ch1 stays in STALE.
- Ch0 in NEAR, strobe d = 3800 (in the band):
  - near stays 1 and H becomes 237.
  - Strobe d = 4200 → FAR, led_out[0] = 1.
  - Strobe d = 3800 → stays FAR.
- STALE_CYCLES = 16:
  - Ch0 strobe d = 1000 with no further strobes → stale[0] rises exactly 16 cycles later and led_out[0] = 1.
  - A strobe arriving on the expiry cycle keeps stale[0] = 0.
- Both channels strobed in the same cycle with ch0 d = 16 and ch1 d = 5000:
  - ch0 toggles every cycle.
  - ch1 is FAR.
  - Async rst pulsed mid-blink → both channels return to reset values within the same cycle.
- Edge values:
  - d = 0 → H = 1.
  - d = 2^32−1 → NEAR not entered.
  - d = 3499 → NEAR.
  - d = 3500 from STALE → FAR.

Source files
------------

// File: rtl/prox_pkg.sv
// Shared types and helpers for the proximity indicator channels.
package prox_pkg;

  // Channel classification. STALE is the reset state.
  typedef enum logic [1:0] {
    STALE = 2'd0,
    FAR   = 2'd1,
    NEAR  = 2'd2
  } prox_state_t;

  // Widest duration word the half-period helper accepts.
  localparam int unsigned MAX_DUR_W = 64;

  // Blink half-period: duration scaled down by the shift, never below one cycle.
  function automatic logic [MAX_DUR_W-1:0] half_period(
    input logic [MAX_DUR_W-1:0] dur,
    input int unsigned          shift
  );
    logic [MAX_DUR_W-1:0] h;
    h = dur >> shift;
    if (h == '0) h = MAX_DUR_W'(1);
    return h;
  endfunction

endpackage

// File: rtl/prox_channel.sv
// One proximity channel: NEAR/FAR/STALE classifier with hysteresis,
// a no-measurement timeout and a distance-proportional LED blinker.
module prox_channel
  import prox_pkg::*;
#(
  parameter int unsigned DUR_W        = 32,
  parameter int unsigned NEAR_THRESH  = 3500,
  parameter int unsigned FAR_THRESH   = 4200,
  parameter int unsigned BLINK_SHIFT  = 4,
  parameter int unsigned STALE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_valid,
  input  logic [DUR_W-1:0] meas_dur,
  output logic             led_out,
  output logic             near,
  output logic             stale
);

  localparam int unsigned      TMR_W   = $clog2(STALE_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STALE_CYCLES);
  localparam logic [DUR_W-1:0] NEAR_T  = DUR_W'(NEAR_THRESH);
  localparam logic [DUR_W-1:0] FAR_T   = DUR_W'(FAR_THRESH);

  prox_state_t      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] bc_q, bc_d;
  logic             lit_q, lit_d;
  logic [DUR_W-1:0] half;

  // Next-state: classification, timeout and blink phase for the coming cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    tmr_d   = tmr_q;
    dur_d   = dur_q;
    lit_d   = 1'b0;
    bc_d    = '0;
    // Half-period comes from the latched duration, so a fresh measurement
    // takes effect for the blink compare one cycle after it arrives.
    half    = DUR_W'(half_period(MAX_DUR_W'(dur_q), BLINK_SHIFT));

    if (meas_valid) begin
      // A measurement always wins over a simultaneous timeout.
      dur_d = meas_dur;
      tmr_d = '0;
      if (meas_dur < NEAR_T)       state_d = NEAR;
      else if (meas_dur >= FAR_T)  state_d = FAR;
      else if (state_q == STALE)   state_d = FAR;  // band from STALE has no history
    end else begin
      if (tmr_q != TMR_MAX) tmr_d = tmr_q + TMR_W'(1);
      if (tmr_d == TMR_MAX) state_d = STALE;
    end

    if (state_d == NEAR) begin
      if (state_q != NEAR) begin
        lit_d = 1'b1;
      end else if (bc_q >= half - DUR_W'(1)) begin
        // Also catches bc overshooting a freshly shortened half-period.
        lit_d = ~lit_q;
      end else begin
        lit_d = lit_q;
        bc_d  = bc_q + DUR_W'(1);
      end
    end
  end

  // State and registered outputs, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= STALE;
      tmr_q   <= '0;
      dur_q   <= '0;
      bc_q    <= '0;
      lit_q   <= 1'b0;
      led_out <= ACTIVE_LOW;
      near    <= 1'b0;
      stale   <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dur_q   <= dur_d;
      bc_q    <= bc_d;
      lit_q   <= lit_d;
      led_out <= lit_d ^ ACTIVE_LOW;
      near    <= (state_d == NEAR);
      stale   <= (state_d == STALE);
    end
  end

endmodule

// File: rtl/prox_indicator.sv
// Multi-channel proximity indicator: N_CH independent prox_channel instances
// fed from a packed duration bus.
module prox_indicator
  import prox_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DUR_W        = 32,
  parameter int unsigned NEAR_THRESH  = 3500,
  parameter int unsigned FAR_THRESH   = 4200,
  parameter int unsigned BLINK_SHIFT  = 4,
  parameter int unsigned STALE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       meas_valid,
  input  logic [N_CH*DUR_W-1:0] meas_dur,
  output logic [N_CH-1:0]       led_out,
  output logic [N_CH-1:0]       near,
  output logic [N_CH-1:0]       stale
);

  // Reject parameter sets the channel logic cannot honour.
  if (FAR_THRESH < NEAR_THRESH) begin : g_bad_thresh
    $error("prox_indicator: FAR_THRESH must be >= NEAR_THRESH");
  end
  if (STALE_CYCLES < 2) begin : g_bad_stale
    $error("prox_indicator: STALE_CYCLES must be >= 2");
  end
  if (DUR_W > MAX_DUR_W) begin : g_bad_width
    $error("prox_indicator: DUR_W exceeds the half-period helper width");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    prox_channel #(
      .DUR_W       (DUR_W),
      .NEAR_THRESH (NEAR_THRESH),
      .FAR_THRESH  (FAR_THRESH),
      .BLINK_SHIFT (BLINK_SHIFT),
      .STALE_CYCLES(STALE_CYCLES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .meas_valid(meas_valid[i]),
      .meas_dur  (meas_dur[i*DUR_W +: DUR_W]),
      .led_out   (led_out[i]),
      .near      (near[i]),
      .stale     (stale[i])
    );
  end

endmodule

// File: tb/tb_prox_indicator.sv
// Scoreboard bench for prox_indicator: stimulus pushes the reference model's
// expected outputs per cycle, a monitor pops and compares after each edge.
module tb_prox_indicator;

  localparam int unsigned N_CH   = 2;
  localparam int unsigned DUR_W  = 32;
  localparam int unsigned S      = 16;
  localparam longint unsigned NEAR_T = 3500;
  localparam longint unsigned FAR_T  = 4200;
  localparam longint unsigned DIV    = 16;   // 2**BLINK_SHIFT

  localparam int M_STALE = 0;
  localparam int M_FAR   = 1;
  localparam int M_NEAR  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       meas_valid;
  logic [N_CH*DUR_W-1:0] meas_dur;
  logic [N_CH-1:0]       led_out, near, stale;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] near;
    logic [1:0] stale;
  } obs_t;

  obs_t  exp_q[$];
  event  sample_ev;
  int    n_cmp = 0;
  int    n_bad = 0;
  string tag = "reset";

  // Behavioural model: mode, last duration, idle cycles, cycles since toggle.
  int              m_mode [N_CH];
  longint unsigned m_dur  [N_CH];
  int              m_idle [N_CH];
  longint unsigned m_since[N_CH];
  bit              m_lit  [N_CH];

  prox_indicator #(
    .N_CH(N_CH), .DUR_W(DUR_W), .NEAR_THRESH(3500), .FAR_THRESH(4200),
    .BLINK_SHIFT(4), .STALE_CYCLES(S), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .meas_valid(meas_valid),
    .meas_dur  (meas_dur),
    .led_out   (led_out),
    .near      (near),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got led=%b near=%b stale=%b, want led=%b near=%b stale=%b",
               name, $time, got.led, got.near, got.stale, exp.led, exp.near, exp.stale);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = M_STALE; m_dur[c] = 0; m_idle[c] = 0; m_since[c] = 0; m_lit[c] = 1'b0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    for (int c = 0; c < N_CH; c++) begin
      o.led[c]   = ~m_lit[c];
      o.near[c]  = (m_mode[c] == M_NEAR);
      o.stale[c] = (m_mode[c] == M_STALE);
    end
    return o;
  endfunction

  // Advance the model by one clock edge.
  task automatic model_step(input logic [N_CH-1:0] v, input logic [N_CH*DUR_W-1:0] dd);
    for (int c = 0; c < N_CH; c++) begin
      longint unsigned d, h_old;
      int nm;
      d     = longint'(dd[c*DUR_W +: DUR_W]);
      h_old = m_dur[c] / DIV;
      if (h_old == 0) h_old = 1;
      nm = m_mode[c];
      if (v[c]) begin
        m_dur[c]  = d;
        m_idle[c] = 0;
        if (d < NEAR_T)             nm = M_NEAR;
        else if (d >= FAR_T)        nm = M_FAR;
        else if (nm == M_STALE)     nm = M_FAR;
      end else begin
        if (m_idle[c] < S) m_idle[c]++;
        if (m_idle[c] >= S) nm = M_STALE;
      end
      if (nm != M_NEAR) begin
        m_lit[c] = 1'b0; m_since[c] = 0;
      end else if (m_mode[c] != M_NEAR) begin
        m_lit[c] = 1'b1; m_since[c] = 0;
      end else begin
        m_since[c]++;
        if (m_since[c] >= h_old) begin
          m_lit[c] = ~m_lit[c]; m_since[c] = 0;
        end
      end
      m_mode[c] = nm;
    end
  endtask

  // One clock: drive inputs on the falling edge, predict, sample after rising edge.
  task automatic cycle(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    meas_valid = v;
    meas_dur   = {d1, d0};
    if (rst) model_reset();
    else     model_step(v, {d1, d0});
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    -> sample_ev;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(2'b00, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_dur();
    logic [31:0] edges [6];
    edges = '{32'd0, 32'd3499, 32'd3500, 32'd4199, 32'd4200, 32'hFFFF_FFFF};
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 300));
      1:       return 32'($urandom_range(0, 3499));
      2:       return 32'($urandom_range(3500, 4199));
      3:       return 32'($urandom_range(4200, 100000));
      4:       return edges[$urandom_range(0, 5)];
      default: return 32'($urandom_range(0, 64));
    endcase
  endfunction

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    obs_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s @%0t: sample with no expected entry", tag, $time);
      end else begin
        e = exp_q.pop_front();
        check(tag, {led_out, near, stale}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    meas_valid = '0;
    meas_dur   = '0;
    model_reset();
    #1;
    exp_q.push_back(model_obs());
    -> sample_ev;
    idle(3);
    rst = 1'b0;

    tag = "idle_after_reset";
    idle(24);

    // d=1600 -> H=100; refreshed every 10 cycles so the timeout never fires.
    tag = "near_1600";
    cycle(2'b01, 32'd1600, 32'd0);
    for (int k = 0; k < 25; k++) begin
      idle(9);
      cycle(2'b01, 32'd1600, 32'd0);
    end

    // Band value keeps NEAR and retunes H to 237.
    tag = "band_3800";
    for (int k = 0; k < 60; k++) begin
      cycle(2'b01, 32'd3800, 32'd0);
      idle(9);
    end

    tag = "far_4200";
    cycle(2'b01, 32'd4200, 32'd0);
    idle(5);
    cycle(2'b01, 32'd3800, 32'd0);
    idle(5);

    tag = "stale_timeout";
    cycle(2'b01, 32'd1000, 32'd0);
    idle(20);

    tag = "expiry_race";
    cycle(2'b01, 32'd1000, 32'd0);
    idle(S - 1);
    cycle(2'b01, 32'd1000, 32'd0);
    idle(5);

    tag = "dual_strobe";
    cycle(2'b11, 32'd16, 32'd5000);
    idle(7);

    // Asynchronous reset between edges, mid-blink.
    tag = "async_reset";
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(model_obs());
    #1;
    -> sample_ev;
    idle(2);
    rst = 1'b0;
    idle(3);

    tag = "edge_values";
    cycle(2'b11, 32'd0, 32'hFFFF_FFFF);
    idle(6);
    cycle(2'b11, 32'd3499, 32'd3500);
    idle(4);
    idle(S + 2);
    cycle(2'b10, 32'd0, 32'd3500);
    idle(3);
    cycle(2'b11, 32'd3500, 32'd3499);
    idle(4);

    tag = "random";
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] v;
      v[0] = ($urandom_range(0, 99) < 9);
      v[1] = ($urandom_range(0, 99) < 9);
      cycle(v, rand_dur(), rand_dur());
    end

    #2;
    tag = "drain";
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
